// File: rtl/opendap_ap_sequencer.sv
// rtl/opendap_ap_sequencer.sv - sequences DP AP accesses onto N_APS downstream access ports
// Optional watchdog on stalled accesses: define OPENDAP_AP_TIMEOUT_EN.
module opendap_ap_sequencer #(
    parameter int N_APS          = 1,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  swclk,
    input  logic                  rst_n,
    input  logic [7:0]            ap_sel,
    input  logic [5:0]            ap_addr,
    input  logic [31:0]           ap_wdata,
    input  logic                  ap_wen,
    input  logic                  ap_ren,
    output logic [31:0]           ap_rdata,
    output logic                  ap_rdy,
    output logic                  ap_err,
    input  logic                  dap_abort,
    output logic                  overrun,
    output logic [N_APS-1:0]      dst_req,
    output logic [5:0]            dst_addr,
    output logic [31:0]           dst_wdata,
    output logic                  dst_write,
    output logic                  dst_abort,
    input  logic [N_APS-1:0]      dst_ack,
    input  logic [N_APS-1:0]      dst_err,
    input  logic [32*N_APS-1:0]   dst_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        BADSEL = 2'd2
    } state_t;

    localparam logic [8:0] NAPS9 = 9'(N_APS);

    state_t      state_q, state_d;
    logic [7:0]  sel_q, sel_d;
    logic [5:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        overrun_q, overrun_d;
    logic        abort_q, abort_d;

    logic        strobe;
    logic        ack_hit;
    logic        err_hit;
    logic [31:0] rdata_hit;
    logic        tmo_hit;

    assign strobe = ap_wen | ap_ren;

    // Only the selected AP's ack/err/rdata are visible to the sequencer.
    always_comb begin
        ack_hit   = 1'b0;
        err_hit   = 1'b0;
        rdata_hit = '0;
        for (int k = 0; k < N_APS; k++) begin
            if (sel_q == 8'(k)) begin
                ack_hit   = dst_ack[k];
                err_hit   = dst_err[k];
                rdata_hit = dst_rdata[32*k +: 32];
            end
        end
    end

`ifdef OPENDAP_AP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;

    // The counter holds the number of REQ cycles already spent without ack.
    assign tmo_hit = (state_q == REQ) && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign cnt_d   = (state_q == REQ) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        overrun_d = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) begin
                    sel_d   = ap_sel;
                    addr_d  = ap_addr;
                    wdata_d = ap_wdata;
                    write_d = ap_wen;
                    err_d   = 1'b0;
                    state_d = ({1'b0, ap_sel} < NAPS9) ? REQ : BADSEL;
                end
            end
            REQ: begin
                overrun_d = strobe;
                // A completing ack beats a concurrent abort or timeout.
                if (ack_hit) begin
                    state_d = IDLE;
                    err_d   = err_hit;
                    if (!write_q) rdata_d = rdata_hit;
                end else if (dap_abort || tmo_hit) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            BADSEL: begin
                overrun_d = strobe;
                state_d   = IDLE;
                err_d     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ap_rdy = (state_q == IDLE);
        for (int k = 0; k < N_APS; k++) begin
            dst_req[k] = (state_q == REQ) && (sel_q == 8'(k));
        end
    end

    assign ap_rdata  = rdata_q;
    assign ap_err    = err_q;
    assign overrun   = overrun_q;
    assign dst_addr  = addr_q;
    assign dst_wdata = wdata_q;
    assign dst_write = write_q;
    assign dst_abort = abort_q;

endmodule

// File: tb/tb_opendap_ap_sequencer.sv
// tb/tb_opendap_ap_sequencer.sv - self-checking bench for opendap_ap_sequencer
module tb_opendap_ap_sequencer;

    localparam int N   = 2;
    localparam int TMO = 4;

    logic          swclk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    ap_sel = '0;
    logic [5:0]    ap_addr = '0;
    logic [31:0]   ap_wdata = '0;
    logic          ap_wen = 1'b0;
    logic          ap_ren = 1'b0;
    logic [31:0]   ap_rdata;
    logic          ap_rdy;
    logic          ap_err;
    logic          dap_abort = 1'b0;
    logic          overrun;
    logic [N-1:0]  dst_req;
    logic [5:0]    dst_addr;
    logic [31:0]   dst_wdata;
    logic          dst_write;
    logic          dst_abort;
    logic [N-1:0]  dst_ack = '0;
    logic [N-1:0]  dst_err = '0;
    logic [32*N-1:0] dst_rdata = '0;

    always #5 swclk = ~swclk;

    opendap_ap_sequencer #(.N_APS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .swclk(swclk), .rst_n(rst_n), .ap_sel(ap_sel), .ap_addr(ap_addr),
        .ap_wdata(ap_wdata), .ap_wen(ap_wen), .ap_ren(ap_ren), .ap_rdata(ap_rdata),
        .ap_rdy(ap_rdy), .ap_err(ap_err), .dap_abort(dap_abort), .overrun(overrun),
        .dst_req(dst_req), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
        .dst_write(dst_write), .dst_abort(dst_abort), .dst_ack(dst_ack),
        .dst_err(dst_err), .dst_rdata(dst_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding access, tracked by who owns it.
    bit          m_pend, m_bad, m_write;
    int          m_sel, m_wait;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    bit          m_err, m_over, m_abort;

    always @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_bad = 0; m_write = 0; m_sel = 0; m_wait = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
            m_err = 0; m_over = 0; m_abort = 0;
        end else begin
            m_over  = 0;
            m_abort = 0;
            if (!m_pend && !m_bad) begin
                if (ap_wen || ap_ren) begin
                    m_sel = int'(ap_sel); m_addr = ap_addr; m_wdata = ap_wdata;
                    m_write = ap_wen; m_err = 0; m_wait = 0;
                    if (m_sel < N) m_pend = 1; else m_bad = 1;
                end
            end else begin
                m_over = ap_wen || ap_ren;
                if (m_bad) begin
                    m_bad = 0; m_err = 1;
                end else if (dst_ack[m_sel]) begin
                    m_pend = 0;
                    m_err  = dst_err[m_sel];
                    if (!m_write) m_rdata = dst_rdata[m_sel*32 +: 32];
                end else if (dap_abort
`ifdef OPENDAP_AP_TIMEOUT_EN
                             || (m_wait + 1 == TMO)
`endif
                            ) begin
                    m_pend = 0; m_abort = 1; m_err = 1;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    always @(negedge swclk) begin
        if (rst_n) begin
            chk("ap_rdy",    64'(ap_rdy),    64'(!(m_pend || m_bad)));
            chk("ap_err",    64'(ap_err),    64'(m_err));
            chk("ap_rdata",  64'(ap_rdata),  64'(m_rdata));
            chk("dst_req",   64'(dst_req),   m_pend ? (64'd1 << m_sel) : 64'd0);
            chk("dst_addr",  64'(dst_addr),  64'(m_addr));
            chk("dst_wdata", 64'(dst_wdata), 64'(m_wdata));
            chk("dst_write", 64'(dst_write), 64'(m_write));
            chk("dst_abort", 64'(dst_abort), 64'(m_abort));
            chk("overrun",   64'(overrun),   64'(m_over));
        end
    end

    task automatic tick();
        @(negedge swclk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int reqcnt;
        bit abort_seen;

        tick(); tick();
        chk("rst_rdy", 64'(ap_rdy), 64'd1);
        chk("rst_err", 64'(ap_err), 64'd0);
        chk("rst_rdata", 64'(ap_rdata), 64'd0);
        chk("rst_req", 64'(dst_req), 64'd0);
        chk("rst_abort", 64'(dst_abort), 64'd0);
        rst_n = 1'b1;
        tick();

        // Read AP0 addr 0x3F, ack on third request cycle
        ap_sel = 8'd0; ap_addr = 6'h3F; ap_ren = 1'b1;
        tick(); ap_ren = 1'b0;
        reqcnt = 0;
        if (dst_req == 2'b01) reqcnt++;
        tick(); if (dst_req == 2'b01) reqcnt++;
        tick(); if (dst_req == 2'b01) reqcnt++;
        chk("t1_busy", 64'(ap_rdy), 64'd0);
        dst_ack = 2'b01; dst_rdata[31:0] = 32'h12345678;
        tick(); dst_ack = '0;
        chk("t1_reqcnt", 64'(reqcnt), 64'd3);
        chk("t1_rdy", 64'(ap_rdy), 64'd1);
        chk("t1_rdata", 64'(ap_rdata), 64'h12345678);
        chk("t1_err", 64'(ap_err), 64'd0);
        chk("t1_addr", 64'(dst_addr), 64'h3F);

        // Write AP1 with a stray ack from AP0 first
        ap_sel = 8'd1; ap_addr = 6'h04; ap_wdata = 32'hCAFEF00D; ap_wen = 1'b1;
        tick(); ap_wen = 1'b0;
        chk("t2_req", 64'(dst_req), 64'b10);
        chk("t2_write", 64'(dst_write), 64'd1);
        chk("t2_wdata", 64'(dst_wdata), 64'hCAFEF00D);
        dst_ack = 2'b01;
        tick(); dst_ack = '0;
        chk("t2_stray", 64'(dst_req), 64'b10);
        dst_ack = 2'b10; dst_err = 2'b10; dst_rdata[63:32] = 32'hDEADBEEF;
        tick(); dst_ack = '0; dst_err = '0;
        chk("t2_err", 64'(ap_err), 64'd1);
        chk("t2_rdata", 64'(ap_rdata), 64'h12345678);

        // Out-of-range select, then a zero-wait read clears ap_err
        ap_sel = 8'd5; ap_ren = 1'b1;
        tick(); ap_ren = 1'b0;
        chk("t3_busy", 64'(ap_rdy), 64'd0);
        chk("t3_noreq", 64'(dst_req), 64'd0);
        tick();
        chk("t3_rdy", 64'(ap_rdy), 64'd1);
        chk("t3_err", 64'(ap_err), 64'd1);
        ap_sel = 8'd1; ap_addr = 6'h08; ap_ren = 1'b1; dst_rdata[63:32] = 32'hA5A50001;
        tick(); ap_ren = 1'b0; dst_ack = 2'b10;
        tick(); dst_ack = '0;
        chk("t3_rdy2", 64'(ap_rdy), 64'd1);
        chk("t3_err2", 64'(ap_err), 64'd0);
        chk("t3_rdata", 64'(ap_rdata), 64'hA5A50001);

        // Overrun during a pending read, then DAPABORT
        ap_sel = 8'd0; ap_addr = 6'h11; ap_ren = 1'b1;
        tick();
        ap_addr = 6'h22;
        tick(); ap_ren = 1'b0;
        chk("t4_over", 64'(overrun), 64'd1);
        chk("t4_addr", 64'(dst_addr), 64'h11);
        tick();
        chk("t4_over0", 64'(overrun), 64'd0);
        dap_abort = 1'b1;
        tick(); dap_abort = 1'b0;
        chk("t4_abort", 64'(dst_abort), 64'd1);
        chk("t4_rdy", 64'(ap_rdy), 64'd1);
        chk("t4_err", 64'(ap_err), 64'd1);
        chk("t4_rdata", 64'(ap_rdata), 64'hA5A50001);
        chk("t4_req", 64'(dst_req), 64'd0);
        tick();
        chk("t4_abort0", 64'(dst_abort), 64'd0);

        // Both strobes: write wins; ack coincident with abort completes normally
        ap_sel = 8'd0; ap_addr = 6'h02; ap_wdata = 32'h0BADC0DE;
        ap_wen = 1'b1; ap_ren = 1'b1;
        tick(); ap_wen = 1'b0; ap_ren = 1'b0;
        chk("t5_write", 64'(dst_write), 64'd1);
        tick();
        dst_ack = 2'b01; dap_abort = 1'b1; dst_rdata[31:0] = 32'h00000055;
        tick(); dst_ack = '0; dap_abort = 1'b0;
        chk("t5_noabort", 64'(dst_abort), 64'd0);
        chk("t5_err", 64'(ap_err), 64'd0);
        chk("t5_rdy", 64'(ap_rdy), 64'd1);
        chk("t5_rdata", 64'(ap_rdata), 64'hA5A50001);

        // Abort while idle does nothing
        dap_abort = 1'b1;
        tick(); dap_abort = 1'b0;
        chk("t5_idleabort", 64'(dst_abort), 64'd0);

        // AP that never acks
        ap_sel = 8'd1; ap_addr = 6'h0C; ap_ren = 1'b1;
        tick(); ap_ren = 1'b0;
`ifdef OPENDAP_AP_TIMEOUT_EN
        reqcnt = 0; abort_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (dst_req != '0) reqcnt++;
            if (dst_abort) abort_seen = 1;
            tick();
        end
        chk("t6_reqcnt", 64'(reqcnt), 64'd4);
        chk("t6_abort", 64'(abort_seen), 64'd1);
        chk("t6_err", 64'(ap_err), 64'd1);
`else
        abort_seen = 0;
        for (int i = 0; i < 2000; i++) tick();
        chk("t6_req", 64'(dst_req), 64'b10);
        chk("t6_busy", 64'(ap_rdy), 64'd0);
        dap_abort = 1'b1;
        tick(); dap_abort = 1'b0;
        chk("t6_abort", 64'(dst_abort), 64'd1);
`endif
        tick();

        // Reset mid-access drops dst_req without a clock edge
        ap_sel = 8'd0; ap_addr = 6'h15; ap_ren = 1'b1;
        tick(); ap_ren = 1'b0;
        chk("t7_req", 64'(dst_req), 64'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_req0", 64'(dst_req), 64'd0);
        chk("t7_rdy", 64'(ap_rdy), 64'd1);
        chk("t7_addr", 64'(dst_addr), 64'd0);
        chk("t7_rdata", 64'(ap_rdata), 64'd0);
        tick(); rst_n = 1'b1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
